// File: rtl/me_consts.sv
// Shared constants for the JVM-to-ARM front-end sequencer: widths, state
// encodings and the `wide` prefix opcode.
package me_consts;

  localparam int SMNL             = 3;
  localparam int adr_rom_adr_size = 8;
  localparam int PARAM_LEN        = 2;
  // One extra bit so a doubled (wide) operand count still fits.
  localparam int CNT_W            = PARAM_LEN + 1;

  localparam logic [7:0] WIDE_OP = 8'hC4;

  typedef enum logic [SMNL-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_PARAM  = 3'd3,
    ST_ISSUE  = 3'd4
  } sm_state_e;

endpackage

// File: rtl/sm_param_counter.sv
// Operand-byte down-counter: loads the operand count in DECODE, decrements
// once per consumed operand byte, toggles the queue slot and flags the last byte.
module sm_param_counter
  import me_consts::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             q_select,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_select_q, q_select_d;

  always_comb begin
    cnt_d      = cnt_q;
    q_select_d = q_select_q;
    if (load) begin
      cnt_d      = load_val;
      q_select_d = 1'b0;
    end else if (dec) begin
      cnt_d      = cnt_q - CNT_W'(1);
      q_select_d = ~q_select_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      q_select_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      q_select_q <= q_select_d;
    end
  end

  assign q_select = q_select_q;
  assign last     = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/state_machine.sv
// Front-end sequencer: fetches a JVM opcode, walks its operand bytes and
// presents opcode/ROM address downstream. SM_WIDE_EN enables `wide` prefix handling.
//
//   state  | meaning
//   IDLE   | post-reset, moves to FETCH unconditionally
//   FETCH  | latch opcode from iram_data (or the wide prefix)
//   DECODE | register ROM address, load operand count
//   PARAM  | consume one operand byte per cycle
//   ISSUE  | hand off to code emission, then FETCH
module state_machine
  import me_consts::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        waiting,
  input  logic [7:0]                  iram_data,
  input  logic [PARAM_LEN-1:0]        parameter_number,
  output logic [SMNL-1:0]             state,
  output logic [adr_rom_adr_size-1:0] com_adr,
  output logic [7:0]                  jvm_opcode,
  output logic                        q_select,
  output logic                        param_even
);

  sm_state_e                   state_q, state_d;
  logic [adr_rom_adr_size-1:0] com_adr_q, com_adr_d;
  logic [7:0]                  jvm_opcode_q, jvm_opcode_d;
  logic                        param_even_q, param_even_d;

  logic             cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0] cnt_load_val;
  logic             decode_even;

`ifdef SM_WIDE_EN
  logic wide_q, wide_d;

  always_comb begin
    cnt_load_val = wide_q ? {parameter_number, 1'b0} : {1'b0, parameter_number};
    decode_even  = wide_q | ~parameter_number[0];
  end
`else
  always_comb begin
    cnt_load_val = {1'b0, parameter_number};
    decode_even  = ~parameter_number[0];
  end
`endif

  always_comb begin
    state_d      = state_q;
    com_adr_d    = com_adr_q;
    jvm_opcode_d = jvm_opcode_q;
    param_even_d = param_even_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
`ifdef SM_WIDE_EN
    wide_d       = wide_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (!waiting) begin
`ifdef SM_WIDE_EN
          if (iram_data == WIDE_OP) begin
            wide_d = 1'b1;
          end else begin
            jvm_opcode_d = iram_data;
            state_d      = ST_DECODE;
          end
`else
          jvm_opcode_d = iram_data;
          state_d      = ST_DECODE;
`endif
        end
      end
      ST_DECODE: begin
        if (!waiting) begin
          com_adr_d    = adr_rom_adr_size'(jvm_opcode_q);
          param_even_d = decode_even;
          cnt_load     = 1'b1;
          state_d      = (cnt_load_val == '0) ? ST_ISSUE : ST_PARAM;
        end
      end
      ST_PARAM: begin
        if (!waiting) begin
          cnt_dec = 1'b1;
          if (cnt_last) state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!waiting) begin
          state_d = ST_FETCH;
`ifdef SM_WIDE_EN
          wide_d  = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      com_adr_q    <= '0;
      jvm_opcode_q <= '0;
      param_even_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      com_adr_q    <= com_adr_d;
      jvm_opcode_q <= jvm_opcode_d;
      param_even_q <= param_even_d;
    end
  end

`ifdef SM_WIDE_EN
  always_ff @(posedge clk) begin
    if (reset) wide_q <= 1'b0;
    else       wide_q <= wide_d;
  end
`endif

  sm_param_counter u_param_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .q_select (q_select),
    .last     (cnt_last)
  );

  assign state      = state_q;
  assign com_adr    = com_adr_q;
  assign jvm_opcode = jvm_opcode_q;
  assign param_even = param_even_q;

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for state_machine: hand-computed state walks, operand slots,
// stalls, mid-instruction reset and (when SM_WIDE_EN is set) the wide prefix.
module tb_state_machine;
  import me_consts::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        waiting;
  logic [7:0]                  iram_data;
  logic [PARAM_LEN-1:0]        parameter_number;
  logic [SMNL-1:0]             state;
  logic [adr_rom_adr_size-1:0] com_adr;
  logic [7:0]                  jvm_opcode;
  logic                        q_select;
  logic                        param_even;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in for the opcode-info ROM, combinational on the latched opcode.
  always_comb begin
    case (jvm_opcode)
      8'h0B:   parameter_number = 2'd2;
      8'h10:   parameter_number = 2'd1;
      8'h11:   parameter_number = 2'd2;
      8'h15:   parameter_number = 2'd1;
      8'h84:   parameter_number = 2'd2;
      default: parameter_number = 2'd0;
    endcase
  end

  state_machine dut (
    .clk              (clk),
    .reset            (reset),
    .waiting          (waiting),
    .iram_data        (iram_data),
    .parameter_number (parameter_number),
    .state            (state),
    .com_adr          (com_adr),
    .jvm_opcode       (jvm_opcode),
    .q_select         (q_select),
    .param_even       (param_even)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int exp);
    check(tag, 32'(state), 32'(exp));
  endtask

  initial begin
    reset     = 1'b1;
    waiting   = 1'b0;
    iram_data = 8'h00;

    // Reset state
    step();
    chk_state("rst_state", 0);
    check("rst_com_adr", 32'(com_adr), 0);
    check("rst_opcode", 32'(jvm_opcode), 0);
    check("rst_qsel", 32'(q_select), 0);
    check("rst_even", 32'(param_even), 0);
    reset = 1'b0;
    step();
    chk_state("idle_to_fetch", 1);

    // Opcode 0x0B, two operands: 1,2,3,3,4,1
    iram_data = 8'h0B;
    step(); chk_state("i0b_decode", 2);
    check("i0b_opcode", 32'(jvm_opcode), 32'h0B);
    iram_data = 8'hA1;
    step(); chk_state("i0b_param0", 3);
    check("i0b_com_adr", 32'(com_adr), 32'h0B);
    check("i0b_even", 32'(param_even), 1);
    check("i0b_qsel0", 32'(q_select), 0);
    iram_data = 8'hA2;
    step(); chk_state("i0b_param1", 3);
    check("i0b_qsel1", 32'(q_select), 1);
    step(); chk_state("i0b_issue", 4);
    step(); chk_state("i0b_fetch", 1);
    check("i0b_com_adr_hold", 32'(com_adr), 32'h0B);

    // Opcode 0x60, no operands: 1,2,4,1
    iram_data = 8'h60;
    step(); chk_state("i60_decode", 2);
    step(); chk_state("i60_issue", 4);
    check("i60_even", 32'(param_even), 1);
    check("i60_com_adr", 32'(com_adr), 32'h60);
    step(); chk_state("i60_fetch", 1);

    // Opcode 0x10, one operand
    iram_data = 8'h10;
    step(); chk_state("i10_decode", 2);
    step(); chk_state("i10_param", 3);
    check("i10_qsel", 32'(q_select), 0);
    check("i10_even", 32'(param_even), 0);
    step(); chk_state("i10_issue", 4);
    step(); chk_state("i10_fetch", 1);

    // Opcode 0x11 with a 3-cycle stall in the first PARAM
    iram_data = 8'h11;
    step(); chk_state("i11_decode", 2);
    step(); chk_state("i11_param0", 3);
    waiting = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state($sformatf("stall%0d_state", i), 3);
      check($sformatf("stall%0d_qsel", i), 32'(q_select), 0);
    end
    waiting = 1'b0;
    step(); chk_state("i11_param1", 3);
    check("i11_qsel1", 32'(q_select), 1);
    step(); chk_state("i11_issue", 4);
    step(); chk_state("i11_fetch", 1);

    // Stall in FETCH must not latch the byte
    iram_data = 8'h15;
    waiting   = 1'b1;
    step(); chk_state("fstall_state", 1);
    check("fstall_opcode", 32'(jvm_opcode), 32'h11);
    waiting = 1'b0;

    // Opcode 0x84, reset asserted mid-PARAM
    iram_data = 8'h84;
    step(); chk_state("i84_decode", 2);
    step(); chk_state("i84_param", 3);
    reset = 1'b1;
    step(); chk_state("mrst_state", 0);
    check("mrst_com_adr", 32'(com_adr), 0);
    check("mrst_opcode", 32'(jvm_opcode), 0);
    check("mrst_qsel", 32'(q_select), 0);
    check("mrst_even", 32'(param_even), 0);
    reset = 1'b0;
    step(); chk_state("mrst_fetch", 1);

`ifdef SM_WIDE_EN
    // wide + 0x15: count doubled to 2, even forced
    iram_data = WIDE_OP;
    step(); chk_state("wide_stay", 1);
    iram_data = 8'h15;
    step(); chk_state("wide_decode", 2);
    check("wide_opcode", 32'(jvm_opcode), 32'h15);
    step(); chk_state("wide_param0", 3);
    check("wide_even", 32'(param_even), 1);
    check("wide_qsel0", 32'(q_select), 0);
    step(); chk_state("wide_param1", 3);
    check("wide_qsel1", 32'(q_select), 1);
    step(); chk_state("wide_issue", 4);
    step(); chk_state("wide_fetch", 1);
    // flag cleared: plain 0x15 has one operand
    step(); chk_state("post_decode", 2);
    step(); chk_state("post_param", 3);
    check("post_even", 32'(param_even), 0);
    step(); chk_state("post_issue", 4);
`else
    // 0xC4 is an ordinary zero-operand opcode
    iram_data = WIDE_OP;
    step(); chk_state("c4_decode", 2);
    check("c4_opcode", 32'(jvm_opcode), 32'hC4);
    step(); chk_state("c4_issue", 4);
    check("c4_com_adr", 32'(com_adr), 32'hC4);
    step(); chk_state("c4_fetch", 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
